// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter that serialises single load/store transactions
// from the CPU (port 0) and the debug/loader (port 1) onto the datamem bus.
module dmem_arbiter #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MEM_DEPTH = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writeData,
    output logic              mem_memWrite,
    output logic              mem_memRead,
    input  logic [DATA_W-1:0] mem_readData
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t            state_q;
    logic              last_q;
    logic              sel_q;
    logic              we_q;
    logic              gnt0_q, gnt1_q;
    logic              done0_q, done1_q;
    logic              err0_q, err1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic [ADDR_W-1:0] mem_address_q;
    logic [DATA_W-1:0] mem_writeData_q;
    logic              mem_memWrite_q;
    logic              mem_memRead_q;

    logic              arb_valid;
    logic              arb_port;
    logic              arb_we;
    logic [ADDR_W-1:0] arb_addr;
    logic [DATA_W-1:0] arb_wdata;
    logic              arb_in_range;

    // Arbitration is only meaningful outside ACCESS; ACCESS never samples requests.
    always_comb begin
        arb_valid = 1'b0;
        arb_port  = 1'b0;
        if (state_q != ACCESS) begin
            arb_valid = req0 | req1;
            if (req0 && req1) begin
                arb_port = ~last_q;
            end else begin
                arb_port = req1;
            end
        end
        arb_we    = arb_port ? we1    : we0;
        arb_addr  = arb_port ? addr1  : addr0;
        arb_wdata = arb_port ? wdata1 : wdata0;
        arb_in_range = (arb_addr < ADDR_W'(MEM_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            last_q          <= 1'b1;
            sel_q           <= 1'b0;
            we_q            <= 1'b0;
            gnt0_q          <= 1'b0;
            gnt1_q          <= 1'b0;
            done0_q         <= 1'b0;
            done1_q         <= 1'b0;
            err0_q          <= 1'b0;
            err1_q          <= 1'b0;
            rdata0_q        <= '0;
            rdata1_q        <= '0;
            mem_address_q   <= '0;
            mem_writeData_q <= '0;
            mem_memWrite_q  <= 1'b0;
            mem_memRead_q   <= 1'b0;
        end else begin
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;

            case (state_q)
                ACCESS: begin
                    mem_address_q   <= '0;
                    mem_writeData_q <= '0;
                    mem_memWrite_q  <= 1'b0;
                    mem_memRead_q   <= 1'b0;
                    state_q         <= RESP;
                    if (sel_q) begin
                        done1_q <= 1'b1;
                        err1_q  <= 1'b0;
                        if (!we_q) begin
                            rdata1_q <= mem_readData;
                        end
                    end else begin
                        done0_q <= 1'b1;
                        err0_q  <= 1'b0;
                        if (!we_q) begin
                            rdata0_q <= mem_readData;
                        end
                    end
                end

                default: begin
                    mem_address_q   <= '0;
                    mem_writeData_q <= '0;
                    mem_memWrite_q  <= 1'b0;
                    mem_memRead_q   <= 1'b0;
                    if (arb_valid) begin
                        last_q <= arb_port;
                        sel_q  <= arb_port;
                        we_q   <= arb_we;
                        if (arb_port) begin
                            gnt1_q <= 1'b1;
                        end else begin
                            gnt0_q <= 1'b1;
                        end
                        if (arb_in_range) begin
                            state_q         <= ACCESS;
                            mem_address_q   <= arb_addr;
                            mem_writeData_q <= arb_wdata;
                            mem_memWrite_q  <= arb_we;
                            mem_memRead_q   <= ~arb_we;
                        end else begin
                            // Out of range: skip the bus entirely, respond with err at once.
                            state_q <= RESP;
                            if (arb_port) begin
                                done1_q <= 1'b1;
                                err1_q  <= 1'b1;
                            end else begin
                                done0_q <= 1'b1;
                                err0_q  <= 1'b1;
                            end
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign gnt0          = gnt0_q;
    assign gnt1          = gnt1_q;
    assign done0         = done0_q;
    assign done1         = done1_q;
    assign err0          = err0_q;
    assign err1          = err1_q;
    assign rdata0        = rdata0_q;
    assign rdata1        = rdata1_q;
    assign mem_address   = mem_address_q;
    assign mem_writeData = mem_writeData_q;
    assign mem_memWrite  = mem_memWrite_q;
    assign mem_memRead   = mem_memRead_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small datamem model (word i holds i after reset).
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, done0, done1, err0, err1;
    logic [15:0] rdata0, rdata1;
    logic [15:0] mem_address, mem_writeData, mem_readData;
    logic        mem_memWrite, mem_memRead;

    int checks = 0;
    int passed = 0;
    int both_cnt = 0;
    int wr_cnt = 0;
    int d0_cnt = 0;
    int snap;

    logic [15:0] mem [0:19];

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_DEPTH(20)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .err0(err0), .err1(err1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_address(mem_address), .mem_writeData(mem_writeData),
        .mem_memWrite(mem_memWrite), .mem_memRead(mem_memRead),
        .mem_readData(mem_readData)
    );

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 20; i++) mem[i] <= 16'(i);
        end else if (mem_memWrite && mem_address < 16'd20) begin
            mem[mem_address[4:0]] <= mem_writeData;
        end
    end

    always @(negedge clk) begin
        mem_readData <= (mem_address < 16'd20) ? mem[mem_address[4:0]] : 16'h0000;
        if (mem_memWrite && mem_memRead) both_cnt++;
        if (mem_memWrite) wr_cnt++;
        if (done0) d0_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        we0 = 1'b0; we1 = 1'b0;
        addr0 = 16'd1; addr1 = 16'd2;
        wdata0 = '0; wdata1 = '0;

        // T1: reset with both requests asserted
        tick();
        tick();
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_done", {done0, done1}, 0);
        chk("rst_err", {err0, err1}, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        chk("rst_mem", {mem_address, mem_writeData, mem_memWrite, mem_memRead}, 0);
        rst_n = 1'b1;

        // T3: contention, both held; order 0,1,0,1
        tick();
        chk("c1_gnt", {gnt0, gnt1}, 2'b10);
        chk("c1_rd", mem_memRead, 1);
        chk("c1_addr", mem_address, 1);
        tick();
        chk("c2_done", {done0, done1, gnt0, gnt1}, 4'b1000);
        chk("c2_rdata0", rdata0, 1);
        chk("c2_mem_idle", {mem_memRead, mem_memWrite}, 0);
        tick();
        chk("c3_gnt", {gnt0, gnt1, done0, done1}, 4'b0100);
        chk("c3_addr", mem_address, 2);
        tick();
        chk("c4_done", {done0, done1, gnt0, gnt1}, 4'b0100);
        chk("c4_rdata1", rdata1, 2);
        tick();
        chk("c5_gnt", {gnt0, gnt1}, 2'b10);
        tick();
        chk("c6_done", {done0, done1}, 2'b10);
        tick();
        chk("c7_gnt", {gnt0, gnt1}, 2'b01);
        req0 = 1'b0; req1 = 1'b0;
        tick();
        chk("c8_done", {done0, done1}, 2'b01);
        tick();
        chk("c9_idle", {gnt0, gnt1, done0, done1}, 0);
        chk("no_both_strobes", both_cnt, 0);

        // T2: store 15 to addr 14, then load it back
        snap = wr_cnt;
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'd14; wdata0 = 16'd15;
        tick();
        chk("st_gnt0", gnt0, 1);
        chk("st_bus", {mem_memWrite, mem_memRead, mem_address, mem_writeData}, {2'b10, 16'd14, 16'd15});
        req0 = 1'b0;
        tick();
        chk("st_done0", {done0, err0}, 2'b10);
        chk("st_wr_off", mem_memWrite, 0);
        tick();
        chk("st_wr_once", wr_cnt - snap, 1);
        chk("st_done_pulse", done0, 0);
        req0 = 1'b1; we0 = 1'b0;
        tick();
        chk("ld_gnt0", {gnt0, mem_memRead, mem_memWrite}, 3'b110);
        req0 = 1'b0;
        tick();
        chk("ld_done0", done0, 1);
        chk("ld_rdata0", rdata0, 15);

        // T4: out-of-range store on port 1, then a valid load
        snap = wr_cnt;
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'd20; wdata1 = 16'd30;
        tick();
        chk("oor_gnt_done_err", {gnt1, done1, err1}, 3'b111);
        chk("oor_no_strobe", {mem_memWrite, mem_memRead}, 0);
        chk("oor_rdata1_held", rdata1, 2);
        req1 = 1'b0;
        tick();
        chk("oor_idle", {gnt1, done1}, 0);
        chk("oor_no_write", wr_cnt - snap, 0);
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'd10;
        tick();
        chk("ld1_gnt", {gnt1, done1, mem_memRead}, 3'b101);
        req1 = 1'b0;
        tick();
        chk("ld1_done_err", {done1, err1}, 2'b10);
        chk("ld1_rdata1", rdata1, 10);

        // T5: reset during ACCESS of a port-0 load
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'd11;
        tick();
        chk("mid_gnt0", {gnt0, mem_memRead}, 2'b11);
        snap = d0_cnt;
        req0 = 1'b0; rst_n = 1'b0;
        tick();
        chk("mid_rst_outs", {gnt0, gnt1, done0, done1, err0, err1, mem_memWrite, mem_memRead}, 0);
        chk("mid_rst_data", {rdata0, rdata1, mem_address, mem_writeData}, 0);
        rst_n = 1'b1;
        tick();
        chk("mid_no_done", d0_cnt - snap, 0);
        req0 = 1'b1;
        tick();
        chk("post_gnt0", gnt0, 1);
        req0 = 1'b0;
        tick();
        chk("post_done0", {done0, err0}, 2'b10);
        chk("post_rdata0", rdata0, 11);

        // T6: streaming loads on port 1
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'd11;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k % 2 == 1) begin
                chk("strm_gnt", {gnt1, done1}, 2'b10);
            end else begin
                chk("strm_done", {gnt1, done1}, 2'b01);
                chk("strm_rdata1", rdata1, 11);
            end
        end
        req1 = 1'b0;
        tick();
        chk("strm_idle", {gnt1, done1}, 0);
        chk("final_no_both_strobes", both_cnt, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
